// File: rtl/exp_inverse_search_if.sv
// Request/result and table-lookup signals of the exponential-decay inverse search.
// The requester raises start with target while busy is low; lut_addr/lut_data form a zero-latency table port.
interface exp_inverse_search_if;
    logic       start;
    logic [7:0] target;
    logic [7:0] lut_addr;
    logic [7:0] lut_data;
    logic       busy;
    logic       done;
    logic [7:0] index;
    logic       miss;

    // Handshake: a request is accepted on any rising edge where start=1 and busy=0
    // (busy low is the ready signal). start while busy is dropped, never queued.
    // done pulses for one cycle when index/miss take their new values.
    modport master (
        output start,
        output target,
        input  lut_addr,
        output lut_data,
        input  busy,
        input  done,
        input  index,
        input  miss
    );

    modport slave (
        input  start,
        input  target,
        output lut_addr,
        input  lut_data,
        output busy,
        output done,
        output index,
        output miss
    );
endinterface

// File: rtl/exp_inverse_search.sv
// Fixed-latency binary search over a 256-entry non-increasing decay table:
// returns the smallest address whose entry is <= target, or flags a miss.
module exp_inverse_search (
    input  logic                       clk,
    input  logic                       rst,
    exp_inverse_search_if.slave        bus,
    output logic [1:0]                 dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] lo_q, lo_d;
    logic [7:0] hi_q, hi_d;
    logic [2:0] step_q, step_d;
    logic [7:0] target_q, target_d;
    logic [7:0] index_q, index_d;
    logic       miss_q, miss_d;

    logic [8:0] mid_sum;
    logic [7:0] mid;
    logic       entry_le;

    // 9-bit sum so lo+hi never wraps before halving.
    assign mid_sum  = {1'b0, lo_q} + {1'b0, hi_q};
    assign mid      = mid_sum[8:1];
    assign entry_le = (bus.lut_data <= target_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            lo_q     <= 8'd0;
            hi_q     <= 8'd255;
            step_q   <= 3'd0;
            target_q <= 8'd0;
            index_q  <= 8'd0;
            miss_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            step_q   <= step_d;
            target_q <= target_d;
            index_q  <= index_d;
            miss_q   <= miss_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        lo_d         = lo_q;
        hi_d         = hi_q;
        step_d       = step_q;
        target_d     = target_q;
        index_d      = index_q;
        miss_d       = miss_q;
        bus.lut_addr = 8'd0;
        bus.done     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    target_d = bus.target;
                    lo_d     = 8'd0;
                    hi_d     = 8'd255;
                    step_d   = 3'd0;
                    state_d  = SEARCH;
                end
            end
            SEARCH: begin
                bus.lut_addr = mid;
                // lo<=hi holds throughout, so mid+1 only occurs with mid<=254.
                if (entry_le) begin
                    hi_d = mid;
                end else begin
                    lo_d = mid + 8'd1;
                end
                step_d = step_q + 3'd1;
                if (step_q == 3'd7) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                bus.lut_addr = lo_q;
                index_d      = lo_q;
                miss_d       = ~entry_le;
                state_d      = DONE;
            end
            DONE: begin
                bus.done = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy  = (state_q != IDLE);
    assign bus.index = index_q;
    assign bus.miss  = miss_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_exp_inverse_search.sv
// Directed and randomized checks of exp_inverse_search against a linear-scan
// reference and a bench-side list of expected probe addresses.
module tb_exp_inverse_search;

    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;

    exp_inverse_search_if bus ();

    exp_inverse_search dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] lut [256];
    assign bus.lut_data = lut[bus.lut_addr];

    int tests_run = 0;
    int tests_failed = 0;

    // scoreboard: expected lut_addr per cycle of one search
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests_run++;
        assert (obs === expv) else begin
            tests_failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Reference: smallest address with entry <= t; none -> (255, miss).
    task automatic ref_scan(input logic [7:0] t, output logic [7:0] idx, output logic m);
        idx = 8'd255;
        m   = 1'b1;
        for (int i = 255; i >= 0; i--) begin
            if (lut[i] <= t) begin
                idx = 8'(i);
                m   = 1'b0;
            end
        end
    endtask

    // Expected probe addresses: eight halving probes, then the final lower bound.
    task automatic build_probes(input logic [7:0] t);
        int lo, hi, mid;
        lo = 0;
        hi = 255;
        exp_q.delete();
        for (int s = 0; s < 8; s++) begin
            mid = (lo + hi) / 2;
            exp_q.push_back(8'(mid));
            if (lut[mid] <= t) hi = mid;
            else               lo = mid + 1;
        end
        exp_q.push_back(8'(lo));
    endtask

    // driver: one search, entered and left on a negedge.
    // dist_k in 0..9 re-raises start with dist_t during that busy cycle.
    task automatic run_search(input logic [7:0] t, input int dist_k, input logic [7:0] dist_t);
        logic [7:0] exp_idx;
        logic       exp_miss;
        logic [7:0] exp_addr;
        ref_scan(t, exp_idx, exp_miss);
        build_probes(t);
        bus.start  = 1'b1;
        bus.target = t;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.target = 8'($urandom_range(0, 255));
        for (int k = 0; k < 10; k++) begin
            check("busy_during", 32'(bus.busy), 32'd1);
            if (k < 9) begin
                exp_addr = exp_q.pop_front();
                check("lut_addr", 32'(bus.lut_addr), 32'(exp_addr));
                check("done_early", 32'(bus.done), 32'd0);
            end else begin
                check("done_pulse", 32'(bus.done), 32'd1);
                check("index", 32'(bus.index), 32'(exp_idx));
                check("miss", 32'(bus.miss), 32'(exp_miss));
            end
            if (k == dist_k) begin
                bus.start  = 1'b1;
                bus.target = dist_t;
            end else begin
                bus.start  = 1'b0;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        check("busy_after", 32'(bus.busy), 32'd0);
        check("done_after", 32'(bus.done), 32'd0);
        check("idle_addr", 32'(bus.lut_addr), 32'd0);
        check("index_hold", 32'(bus.index), 32'(exp_idx));
        check("miss_hold", 32'(bus.miss), 32'(exp_miss));
    endtask

    initial begin
        logic [7:0] v;
        logic [7:0] t;
        rst        = 1'b1;
        bus.start  = 1'b1;
        bus.target = 8'd77;
        for (int i = 0; i < 256; i++) lut[i] = 8'(255 - i);

        // reset state, with start held high to exercise reset priority
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_index", 32'(bus.index), 32'd0);
        check("rst_miss", 32'(bus.miss), 32'd0);
        check("rst_addr", 32'(bus.lut_addr), 32'd0);
        rst       = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        check("idle_busy", 32'(bus.busy), 32'd0);

        // linear descending table
        run_search(8'd100, -1, 8'd0);
        run_search(8'd255, -1, 8'd0);
        run_search(8'd0,   -1, 8'd0);

        // constant table
        for (int i = 0; i < 256; i++) lut[i] = 8'd50;
        run_search(8'd10, -1, 8'd0);
        run_search(8'd50, -1, 8'd0);

        // second start with a new target while busy, and start during DONE
        for (int i = 0; i < 256; i++) lut[i] = 8'(255 - i);
        run_search(8'd100, 2, 8'd7);
        run_search(8'd100, 9, 8'd3);
        repeat (2) begin
            check("no_requeue_busy", 32'(bus.busy), 32'd0);
            @(negedge clk);
        end

        // reset during SEARCH step 4 abandons the search
        bus.start  = 1'b1;
        bus.target = 8'd40;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_rst_busy", 32'(bus.busy), 32'd1);
        rst       = 1'b1;
        bus.start = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("midrst_busy", 32'(bus.busy), 32'd0);
            check("midrst_done", 32'(bus.done), 32'd0);
            check("midrst_index", 32'(bus.index), 32'd0);
            check("midrst_miss", 32'(bus.miss), 32'd0);
        end
        rst = 1'b0;
        run_search(8'd200, -1, 8'd0);

        // real decay table, full target sweep
        for (int i = 0; i < 256; i++) lut[i] = 8'(int'(255.0 * $exp(-real'(i) / 48.0)));
        for (int k = 0; k < 256; k++) run_search(8'(k), -1, 8'd0);

        // random monotone tables, random targets and random disturbances
        for (int r = 0; r < 24; r++) begin
            v = 8'($urandom_range(0, 255));
            for (int i = 0; i < 256; i++) begin
                lut[i] = v;
                t = 8'($urandom_range(0, 3));
                v = (v > t) ? v - t : 8'd0;
            end
            if ($urandom_range(0, 1) == 1) t = lut[$urandom_range(0, 255)];
            else                           t = 8'($urandom_range(0, 255));
            run_search(t, int'($urandom_range(0, 12)), 8'($urandom_range(0, 255)));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
